f_pc_unit: RTL and testbench

Fetch-stage program-counter unit, directly upstream of the F/D pipeline register.
- Holds F_pc and selects next PC among sequential, branch/jump redirect, eret return and exception-handler entry.
- Flags fetch address errors (AdEL) and delay-slot status.
- Its F_pc, F_exCode, F_isBD and F_kill outputs feed the F/D register and the instruction memory.

---
 rtl/f_pc_unit_pkg.sv | 20 ++
 rtl/f_pc_unit_if.sv | 24 ++
 rtl/f_addr_check.sv | 11 +
 rtl/f_pc_unit.sv | 65 ++++++
 tb/tb_f_pc_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/f_pc_unit_pkg.sv
// rtl/f_pc_unit_pkg.sv - shared constants and types for the fetch-stage PC unit
package f_pc_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEF   = 32'h0000_3000;
    localparam logic [31:0] IM_END_DEF    = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [2:0] {
        NPC_EXC,
        NPC_EPC,
        NPC_HOLD,
        NPC_JUMP,
        NPC_SEQ
    } npc_sel_t;

endpackage

// File: rtl/f_pc_unit_if.sv
// rtl/f_pc_unit_if.sv - control inputs and fetch outputs of the PC unit
interface f_pc_unit_if;
    logic        F_en;
    logic        intReq;
    logic        eretReq;
    logic [31:0] EPC;
    logic        D_jump;
    logic [31:0] D_target;
    logic        D_isJump;
    logic [31:0] F_pc;
    logic [4:0]  F_exCode;
    logic        F_isBD;
    logic        F_kill;

    modport master (
        output F_en, intReq, eretReq, EPC, D_jump, D_target, D_isJump,
        input  F_pc, F_exCode, F_isBD, F_kill
    );

    modport slave (
        input  F_en, intReq, eretReq, EPC, D_jump, D_target, D_isJump,
        output F_pc, F_exCode, F_isBD, F_kill
    );
endinterface

// File: rtl/f_addr_check.sv
// rtl/f_addr_check.sv - word-alignment and range check for a memory address
module f_addr_check #(
    parameter logic [31:0] LO = 32'h0000_3000,
    parameter logic [31:0] HI = 32'h0000_6FFC
) (
    input  logic [31:0] addr,
    output logic        adel
);
    // HI is inclusive: it is the address of the last legal word.
    assign adel = (addr[1:0] != 2'b00) || (addr < LO) || (addr > HI);
endmodule

// File: rtl/f_pc_unit.sv
// rtl/f_pc_unit.sv - fetch PC register with redirect priority and AdEL flagging
module f_pc_unit
    import f_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter logic [31:0] IM_BASE   = IM_BASE_DEF,
    parameter logic [31:0] IM_END    = IM_END_DEF
) (
    input  logic          clk,
    input  logic          reset,
    f_pc_unit_if.slave    bus
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    npc_sel_t    sel;
    logic        adel;

    // Interrupt entry must win even over a stall; eret only moves when F is enabled.
    always_comb begin
        sel = NPC_SEQ;
        if (bus.intReq)
            sel = NPC_EXC;
        else if (bus.eretReq && bus.F_en)
            sel = NPC_EPC;
        else if (!bus.F_en)
            sel = NPC_HOLD;
        else if (bus.D_jump)
            sel = NPC_JUMP;
    end

    always_comb begin
        pc_next = pc + 32'd4;
        case (sel)
            NPC_EXC:  pc_next = EXC_ENTRY;
            NPC_EPC:  pc_next = bus.EPC;
            NPC_HOLD: pc_next = pc;
            NPC_JUMP: pc_next = bus.D_target;
            default:  pc_next = pc + 32'd4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    f_addr_check #(
        .LO (IM_BASE),
        .HI (IM_END)
    ) u_addr_check (
        .addr (pc),
        .adel (adel)
    );

    // AdEL does not kill the word; it travels down with its exception code.
    assign bus.F_pc     = pc;
    assign bus.F_exCode = adel ? EXC_ADEL : EXC_NONE;
    assign bus.F_isBD   = bus.D_isJump & ~bus.eretReq;
    assign bus.F_kill   = bus.eretReq & bus.F_en & ~bus.intReq;

endmodule

// File: tb/tb_f_pc_unit.sv
// tb/tb_f_pc_unit.sv - self-checking bench for f_pc_unit
module tb_f_pc_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    f_pc_unit_if bus ();

    f_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic        er;
        logic        en;
        logic        dj;
        logic        isj;
        logic [31:0] epc;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        kill;
        logic        bd;
        logic [31:0] nxt;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic er, input logic en, input logic dj,
                         input logic isj, input logic [31:0] epc, input logic [31:0] tgt);
        bus.intReq   = ir;
        bus.eretReq  = er;
        bus.F_en     = en;
        bus.D_jump   = dj;
        bus.D_isJump = isj;
        bus.EPC      = epc;
        bus.D_target = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic vec_t mk(logic ir, logic er, logic en, logic dj, logic isj,
                                logic [31:0] epc, logic [31:0] tgt, logic [31:0] pc,
                                logic [4:0] exc, logic kill, logic bd, logic [31:0] nxt);
        vec_t v;
        v.ir = ir; v.er = er; v.en = en; v.dj = dj; v.isj = isj;
        v.epc = epc; v.tgt = tgt; v.pc = pc; v.exc = exc;
        v.kill = kill; v.bd = bd; v.nxt = nxt;
        return v;
    endfunction

    // Reference rules, written directly from the behaviour description.
    function automatic logic [31:0] ref_next(logic [31:0] pc, logic ir, logic er, logic en,
                                             logic dj, logic [31:0] epc, logic [31:0] tgt);
        if (ir) return 32'h0000_4180;
        if (er && en) return epc;
        if (!en) return pc;
        if (dj) return tgt;
        return pc + 32'd4;
    endfunction

    function automatic logic [4:0] ref_exc(logic [31:0] pc);
        if ((pc % 4) != 0 || pc < 32'h3000 || pc > 32'h6FFC) return 5'd4;
        return 5'd0;
    endfunction

    logic [31:0] model_pc;
    logic        r_ir, r_er, r_en, r_dj, r_isj;
    logic [31:0] r_epc, r_tgt;

    initial begin
        checks = 0;
        errors = 0;
        idle();
        reset = 1'b0;

        vecs[0]  = mk(0,0,1,0,0, 32'h0,    32'h0,        32'h3000,     5'd0, 0,0, 32'h3004);
        vecs[1]  = mk(0,0,1,0,0, 32'h0,    32'h0,        32'h3004,     5'd0, 0,0, 32'h3008);
        vecs[2]  = mk(0,0,1,1,1, 32'h0,    32'h3100,     32'h3008,     5'd0, 0,1, 32'h3100);
        vecs[3]  = mk(0,0,0,1,1, 32'h0,    32'h3200,     32'h3100,     5'd0, 0,1, 32'h3100);
        vecs[4]  = mk(1,1,0,1,1, 32'h3300, 32'h3200,     32'h3100,     5'd0, 0,0, 32'h4180);
        vecs[5]  = mk(0,1,1,0,1, 32'h3044, 32'h0,        32'h4180,     5'd0, 1,0, 32'h3044);
        vecs[6]  = mk(0,1,0,0,0, 32'h3500, 32'h0,        32'h3044,     5'd0, 0,0, 32'h3044);
        vecs[7]  = mk(0,0,1,1,1, 32'h0,    32'h3002,     32'h3044,     5'd0, 0,1, 32'h3002);
        vecs[8]  = mk(0,0,1,0,0, 32'h0,    32'h0,        32'h3002,     5'd4, 0,0, 32'h3006);
        vecs[9]  = mk(0,0,1,1,1, 32'h0,    32'h7000,     32'h3006,     5'd4, 0,1, 32'h7000);
        vecs[10] = mk(0,0,1,0,0, 32'h0,    32'h0,        32'h7000,     5'd4, 0,0, 32'h7004);
        vecs[11] = mk(0,0,1,1,0, 32'h0,    32'h6FFC,     32'h7004,     5'd4, 0,0, 32'h6FFC);
        vecs[12] = mk(0,0,1,0,0, 32'h0,    32'h0,        32'h6FFC,     5'd0, 0,0, 32'h7000);
        vecs[13] = mk(0,0,1,1,0, 32'h0,    32'h2FFC,     32'h7000,     5'd4, 0,0, 32'h2FFC);
        vecs[14] = mk(0,0,1,1,0, 32'h0,    32'hFFFF_FFFC, 32'h2FFC,    5'd4, 0,0, 32'hFFFF_FFFC);
        vecs[15] = mk(0,0,1,0,0, 32'h0,    32'h0,        32'hFFFF_FFFC, 5'd4, 0,0, 32'h0000_0000);
        vecs[16] = mk(1,1,1,1,0, 32'h3044, 32'h3100,     32'h0,        5'd4, 0,0, 32'h4180);
        vecs[17] = mk(0,0,1,0,1, 32'h0,    32'h3100,     32'h4180,     5'd0, 0,1, 32'h4184);

        // Reset held for two edges, then idle fetch.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", bus.F_pc, 32'h3000);
        chk("reset_exc", {27'h0, bus.F_exCode}, 32'h0);
        chk("reset_kill", {31'h0, bus.F_kill}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].ir, vecs[i].er, vecs[i].en, vecs[i].dj, vecs[i].isj,
                  vecs[i].epc, vecs[i].tgt);
            #1;
            chk($sformatf("v%0d_pc", i), bus.F_pc, vecs[i].pc);
            chk($sformatf("v%0d_exc", i), {27'h0, bus.F_exCode}, {27'h0, vecs[i].exc});
            chk($sformatf("v%0d_kill", i), {31'h0, bus.F_kill}, {31'h0, vecs[i].kill});
            chk($sformatf("v%0d_bd", i), {31'h0, bus.F_isBD}, {31'h0, vecs[i].bd});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_next", i), bus.F_pc, vecs[i].nxt);
            @(negedge clk);
        end

        // Three-cycle stall with a pending redirect, then release.
        drive(0,0,1,1,0, 32'h0, 32'h3010);
        @(posedge clk); #1;
        chk("stall_setup", bus.F_pc, 32'h3010);
        @(negedge clk);
        drive(0,0,0,1,1, 32'h0, 32'h3100);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_hold%0d", i), bus.F_pc, 32'h3010);
            @(negedge clk);
        end
        bus.F_en = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", bus.F_pc, 32'h3100);
        @(negedge clk);

        // Asynchronous reset between edges, with a redirect pending.
        drive(0,0,1,1,0, 32'h0, 32'h3040);
        @(posedge clk); #1;
        chk("areset_setup", bus.F_pc, 32'h3040);
        @(negedge clk);
        drive(0,0,1,1,0, 32'h0, 32'h3500);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_immediate", bus.F_pc, 32'h3000);
        @(posedge clk); #1;
        chk("areset_held", bus.F_pc, 32'h3000);
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("areset_resume", bus.F_pc, 32'h3004);
        @(negedge clk);

        // Randomized traffic against the reference rules.
        model_pc = 32'h3004;
        for (int i = 0; i < 400; i++) begin
            r_ir  = ($urandom_range(0, 15) == 0);
            r_er  = ($urandom_range(0, 9) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_dj  = ($urandom_range(0, 4) == 0);
            r_isj = r_dj | ($urandom_range(0, 5) == 0);
            r_epc = 32'h3000 + ($urandom_range(0, 4095) << 2);
            r_tgt = ($urandom_range(0, 7) == 0) ? $urandom()
                                                : 32'h2F00 + ($urandom_range(0, 4200) << 2);
            drive(r_ir, r_er, r_en, r_dj, r_isj, r_epc, r_tgt);
            #1;
            chk("rnd_pc", bus.F_pc, model_pc);
            chk("rnd_exc", {27'h0, bus.F_exCode}, {27'h0, ref_exc(model_pc)});
            chk("rnd_kill", {31'h0, bus.F_kill}, {31'h0, (r_er && r_en && !r_ir)});
            chk("rnd_bd", {31'h0, bus.F_isBD}, {31'h0, (r_isj && !r_er)});
            model_pc = ref_next(model_pc, r_ir, r_er, r_en, r_dj, r_epc, r_tgt);
            @(posedge clk); #1;
            chk("rnd_next", bus.F_pc, model_pc);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
